// File: rtl/tl_ul_rr_arbiter.sv
// tl_ul_rr_arbiter: N-master to 1-slave TileLink-UL arbiter.
// Round-robin grant with burst lock on multi-beat Puts, per-master
// outstanding-message limit, and D-channel routing by the master index
// prepended to the A-channel source.
// Optional build macro TL_ARB_STARVE_EN adds STARVE_LIMIT and per-master
// wait counters that let a starved master override round-robin.
module tl_ul_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SRC_W       = 1,
  parameter int SIZE_W      = 4,
  parameter int MAX_OUT     = 4
`ifdef TL_ARB_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 16
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_MASTERS*3-1:0]             m_a_opcode,
  input  logic [NUM_MASTERS*3-1:0]             m_a_param,
  input  logic [NUM_MASTERS*SIZE_W-1:0]        m_a_size,
  input  logic [NUM_MASTERS*SRC_W-1:0]         m_a_source,
  input  logic [NUM_MASTERS*ADDR_W-1:0]        m_a_address,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]    m_a_mask,
  input  logic [NUM_MASTERS*DATA_W-1:0]        m_a_data,
  input  logic [NUM_MASTERS-1:0]               m_a_corrupt,
  input  logic [NUM_MASTERS-1:0]               m_a_valid,
  output logic [NUM_MASTERS-1:0]               m_a_ready,
  output logic [NUM_MASTERS*3-1:0]             m_d_opcode,
  output logic [NUM_MASTERS*2-1:0]             m_d_param,
  output logic [NUM_MASTERS*SIZE_W-1:0]        m_d_size,
  output logic [NUM_MASTERS*SRC_W-1:0]         m_d_source,
  output logic [NUM_MASTERS-1:0]               m_d_denied,
  output logic [NUM_MASTERS*DATA_W-1:0]        m_d_data,
  output logic [NUM_MASTERS-1:0]               m_d_corrupt,
  output logic [NUM_MASTERS-1:0]               m_d_valid,
  input  logic [NUM_MASTERS-1:0]               m_d_ready,
  output logic [2:0]                           s_a_opcode,
  output logic [2:0]                           s_a_param,
  output logic [SIZE_W-1:0]                    s_a_size,
  output logic [SRC_W+$clog2(NUM_MASTERS)-1:0] s_a_source,
  output logic [ADDR_W-1:0]                    s_a_address,
  output logic [DATA_W/8-1:0]                  s_a_mask,
  output logic [DATA_W-1:0]                    s_a_data,
  output logic                                 s_a_corrupt,
  output logic                                 s_a_valid,
  input  logic                                 s_a_ready,
  input  logic [2:0]                           s_d_opcode,
  input  logic [1:0]                           s_d_param,
  input  logic [SIZE_W-1:0]                    s_d_size,
  input  logic [SRC_W+$clog2(NUM_MASTERS)-1:0] s_d_source,
  input  logic                                 s_d_denied,
  input  logic [DATA_W-1:0]                    s_d_data,
  input  logic                                 s_d_corrupt,
  input  logic                                 s_d_valid,
  output logic                                 s_d_ready
);

  localparam int IDX_W     = $clog2(NUM_MASTERS);
  localparam int BYTES     = DATA_W / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int CNT_W     = $clog2(MAX_OUT + 1);
  localparam int BEAT_W    = 16;

  // Beats beyond the first for a message; burst_op selects Put (A) or AccessAckData (D).
  function automatic logic [BEAT_W-1:0] extra_beats(input logic burst_op,
                                                    input logic [SIZE_W-1:0] size);
    if (burst_op && int'(size) > LOG_BYTES)
      return BEAT_W'((1 << (int'(size) - LOG_BYTES)) - 1);
    return '0;
  endfunction

  logic                   lock;
  logic [IDX_W-1:0]       owner;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       out_cnt [NUM_MASTERS];
  logic [BEAT_W-1:0]      d_beat_cnt;

  logic [NUM_MASTERS-1:0] elig;
  logic [IDX_W-1:0]       rr_grant;
  logic                   rr_found;
  logic [IDX_W-1:0]       grant;
  logic                   grant_ok;
  logic                   a_fire;
  logic [BEAT_W-1:0]      a_extra;
  logic [IDX_W-1:0]       d_idx;
  logic                   d_hit;
  logic                   d_fire;
  logic                   d_last;
  logic [BEAT_W-1:0]      d_extra;

`ifdef TL_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  logic [WAIT_W-1:0] wait_cnt [NUM_MASTERS];
  logic              starve_hit;
  logic [IDX_W-1:0]  starve_idx;

  // Lowest-index eligible master whose wait counter has hit the limit.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (elig[i] && wait_cnt[i] >= WAIT_W'(STARVE_LIMIT)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  // Wait counters: count cycles eligible-but-not-granted, clear on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MASTERS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (s_a_valid && grant == IDX_W'(i)) wait_cnt[i] <= '0;
        else if (elig[i] && wait_cnt[i] < WAIT_W'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end
`endif

  // Eligibility and round-robin scan starting just after the last winner.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    elig     = '0;
    rr_grant = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++)
      elig[i] = m_a_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!rr_found && elig[(int'(rr_ptr) + k) % NUM_MASTERS]) begin
        rr_found = 1'b1;
        rr_grant = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      end
    end
  end

  // Final grant: burst owner first, then starvation override, then round-robin.
  always_comb begin
    grant    = rr_grant;
    grant_ok = rr_found;
`ifdef TL_ARB_STARVE_EN
    if (starve_hit) begin
      grant    = starve_idx;
      grant_ok = 1'b1;
    end
`endif
    if (lock) begin
      grant    = owner;
      grant_ok = 1'b1;
    end
  end

  // A-channel mux from the granted master; everything held quiet in reset.
  always_comb begin
    s_a_opcode  = m_a_opcode[int'(grant)*3 +: 3];
    s_a_param   = m_a_param[int'(grant)*3 +: 3];
    s_a_size    = m_a_size[int'(grant)*SIZE_W +: SIZE_W];
    s_a_source  = {grant, m_a_source[int'(grant)*SRC_W +: SRC_W]};
    s_a_address = m_a_address[int'(grant)*ADDR_W +: ADDR_W];
    s_a_mask    = m_a_mask[int'(grant)*BYTES +: BYTES];
    s_a_data    = m_a_data[int'(grant)*DATA_W +: DATA_W];
    s_a_corrupt = m_a_corrupt[grant];
    s_a_valid   = rst_n && grant_ok && m_a_valid[grant];
    m_a_ready   = '0;
    m_a_ready[grant] = rst_n && grant_ok && s_a_ready;
  end

  assign a_fire  = s_a_valid && s_a_ready;
  assign a_extra = extra_beats(s_a_opcode == 3'd0 || s_a_opcode == 3'd1, s_a_size);

  // D-channel routing by the index in the upper source bits; unknown index is sunk.
  assign d_idx = s_d_source[SRC_W +: IDX_W];
  assign d_hit = int'(d_idx) < NUM_MASTERS;

  always_comb begin
    m_d_valid = '0;
    s_d_ready = 1'b0;
    if (rst_n) begin
      if (d_hit) begin
        m_d_valid[d_idx] = s_d_valid;
        s_d_ready        = m_d_ready[d_idx];
      end else begin
        s_d_ready = 1'b1;
      end
    end
  end

  assign m_d_opcode  = {NUM_MASTERS{s_d_opcode}};
  assign m_d_param   = {NUM_MASTERS{s_d_param}};
  assign m_d_size    = {NUM_MASTERS{s_d_size}};
  assign m_d_source  = {NUM_MASTERS{s_d_source[SRC_W-1:0]}};
  assign m_d_denied  = {NUM_MASTERS{s_d_denied}};
  assign m_d_data    = {NUM_MASTERS{s_d_data}};
  assign m_d_corrupt = {NUM_MASTERS{s_d_corrupt}};

  assign d_fire  = s_d_valid && s_d_ready && d_hit;
  assign d_extra = extra_beats(s_d_opcode == 3'd1, s_d_size);
  assign d_last  = d_fire && ((d_beat_cnt == '0 && d_extra == '0) ||
                              d_beat_cnt == BEAT_W'(1));

  // Burst lock, beat countdown and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (!rst_n) begin
      lock     <= 1'b0;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IDX_W'(NUM_MASTERS - 1);
    end else if (a_fire) begin
      if (lock) begin
        if (beat_cnt == BEAT_W'(1)) begin
          lock     <= 1'b0;
          beat_cnt <= '0;
          rr_ptr   <= owner;
        end else begin
          beat_cnt <= beat_cnt - 1'b1;
        end
      end else if (a_extra != '0) begin
        lock     <= 1'b1;
        owner    <= grant;
        beat_cnt <= a_extra;
      end else begin
        rr_ptr <= grant;
      end
    end
  end

  // D beat counter so only the last beat of AccessAckData retires a message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_beat_cnt <= '0;
    else if (d_fire) d_beat_cnt <= (d_beat_cnt == '0) ? d_extra : d_beat_cnt - 1'b1;
  end

  // Per-master outstanding counters, saturating in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: out_cnt is a small flop array, not a RAM, so each element is reset.
      for (int i = 0; i < NUM_MASTERS; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (a_fire && !lock && grant == IDX_W'(i)) begin
          if (!(d_last && d_idx == IDX_W'(i)) && out_cnt[i] != CNT_W'(MAX_OUT))
            out_cnt[i] <= out_cnt[i] + 1'b1;
        end else if (d_last && d_idx == IDX_W'(i) && out_cnt[i] != '0) begin
          out_cnt[i] <= out_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tl_ul_rr_arbiter.md
Name: tl_ul_rr_arbiter

Overview:
N-master to 1-slave TileLink-UL arbiter with round-robin grant, burst lock and per-master outstanding-request limiting. Sits between cache/bridge masters (icache, dcache-side memory port, ACP) and a single shared slave such as the on-chip SRAM. Master index is prepended to the A-channel source, and D responses are routed back by that index.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)
SRC_W, 1, per-master source width
SIZE_W, 4, TileLink size field width
MAX_OUT, 4, maximum outstanding messages per master (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_a_opcode/param  in  NUM_MASTERS*3 each  packed master A opcode, param
m_a_size  in  NUM_MASTERS*SIZE_W  master A size
m_a_source  in  NUM_MASTERS*SRC_W  master A source
m_a_address  in  NUM_MASTERS*ADDR_W  master A address
m_a_mask/data/corrupt  in  NUM_MASTERS*(DATA_W/8), NUM_MASTERS*DATA_W, NUM_MASTERS  master A payload
m_a_valid  in  NUM_MASTERS  master A valid
m_a_ready  out  NUM_MASTERS  master A ready
m_d_opcode/param/size/source/denied/data/corrupt  out  packed NUM_MASTERS copies  master D payload (broadcast copy of slave D)
m_d_valid  out  NUM_MASTERS  master D valid
m_d_ready  in  NUM_MASTERS  master D ready
s_a_opcode/param/size/address/mask/data/corrupt  out  single-width  slave A payload, muxed from granted master
s_a_source  out  SRC_W+clog2(NUM_MASTERS)  {master index, master source}
s_a_valid  out  1  slave A valid
s_a_ready  in  1  slave A ready
s_d_opcode/param/size/source/denied/data/corrupt  in  single-width  slave D payload
s_d_valid  in  1  slave D valid
s_d_ready  out  1  slave D ready

Behaviour:
- Reset (rst_n low): lock=0, owner=0, beat_cnt=0, rr_ptr=NUM_MASTERS-1 (master 0 wins first), all out_cnt=0. While in reset: all m_a_ready=0, s_a_valid=0, m_d_valid=0, s_d_ready=0.
- Eligibility: master i is eligible when m_a_valid[i]=1 and out_cnt[i]<MAX_OUT. A burst continuation beat is never blocked by out_cnt.
- Grant (combinational, zero latency): if lock=1, grant=owner. Otherwise grant=first eligible index scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_MASTERS. No eligible master gives s_a_valid=0.
- s_a_valid=m_a_valid[grant] (when lock=1 or the granted master is eligible). m_a_ready[grant]=s_a_ready. All other m_a_ready are 0.
- Beats per message: PutFullData(0)/PutPartialData(1) with 2^size > DATA_W/8 take 2^size/(DATA_W/8) beats. All other messages take 1 beat.
- Lock:
  - On a first-beat fire of a multi-beat message: lock=1, owner=grant, beat_cnt=beats-1.
  - On each later fire: beat_cnt decrements.
  - On the last beat: lock=0 and rr_ptr=owner.
  - A single-beat fire sets rr_ptr=grant.
- Outstanding count: out_cnt[i] increments on the first-beat A fire from master i. It decrements on the last D beat for index i. D messages are multi-beat only for AccessAckData(1) with 2^size > DATA_W/8, using a separate D beat counter. Simultaneous increment and decrement leaves the count unchanged. The count saturates and never wraps.
- D routing (combinational): idx=s_d_source[MSB:SRC_W]. m_d_valid[idx]=s_d_valid and s_d_ready=m_d_ready[idx]. m_d_source gets the low SRC_W bits. An idx >= NUM_MASTERS gives s_d_ready=1, the beat is discarded, and no counter changes.
- A and D fire in the same cycle independently.
- Reset asserted mid-burst: lock clears and the partial burst is abandoned (slave is reset with the same rst_n).

Optional Feature:
- Macro TL_ARB_STARVE_EN adds parameter STARVE_LIMIT (default 16) and a per-master wait counter.
  - The wait counter increments each cycle the master is eligible but not granted, and clears on its grant.
  - When a counter reaches STARVE_LIMIT and lock=0, that master (lowest index if several) overrides round-robin.
- Without the macro: pure round-robin, no wait counters synthesised.

Test Plan:
1. Masters 0,1 issue continuous single-beat Gets (size=2), slave ready=1 -> grants alternate 0,1,0,1; s_a_source MSB matches the master.
2. Master 1 issues PutFullData size=4 (4 beats, DATA_W=32) while master 0 is valid -> 4 consecutive master-1 beats, master 0 granted on cycle 5.
3. MAX_OUT=2, slave withholds D, master 0 sends 3 Gets -> the third stalls (m_a_ready[0]=0) until one AccessAckData returns, then it issues the next cycle.
4. Slave returns D with source {1,0} while m_d_ready[1]=0 for 3 cycles -> s_d_ready=0 for 3 cycles, m_d_valid[0]=0 throughout, delivered on cycle 4.
5. rst_n dropped during beat 2 of a 4-beat Put -> next cycle all readies 0 and lock=0; after release master 0 wins first.
6. (TL_ARB_STARVE_EN, STARVE_LIMIT=4) master 1 Put bursts back-to-back, master 0 valid -> master 0 granted immediately after the burst that completes while its wait count reaches 4.
